// File: rtl/riscv_test_monitor_pkg.sv
// rtl/riscv_test_monitor_pkg.sv - shared state encoding, default register indices and LED decode
// for the end-of-test monitor.
package riscv_test_monitor_pkg;

   localparam int TMON_CPU_WIDTH = 32;
   localparam int TMON_END_REG   = 26;
   localparam int TMON_RES_REG   = 27;
   localparam int TMON_NUM_REG   = 3;

   typedef enum logic [2:0] {
      TMON_IDLE    = 3'd0,
      TMON_RUN     = 3'd1,
      TMON_CHECK   = 3'd2,
      TMON_PASS    = 3'd3,
      TMON_FAIL    = 3'd4,
      TMON_TIMEOUT = 3'd5
   } tmon_state_e;

   function automatic logic [1:0] tmon_led(input tmon_state_e s, input logic blink);
      logic [1:0] l;
      case (s)
         TMON_PASS:    l = 2'b01;
         TMON_FAIL:    l = 2'b10;
         TMON_TIMEOUT: l = {blink, blink};
         default:      l = 2'b00;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/tmon_sat_cnt.sv
// rtl/tmon_sat_cnt.sv - saturating up-counter with synchronous clear; clear beats enable.
module tmon_sat_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else if (clr) begin
         q_q <= '0;
      end else if (en && (q_q != {W{1'b1}})) begin
         q_q <= q_q + W'(1);
      end
   end

   assign q = q_q;

endmodule

// File: rtl/riscv_test_monitor.sv
// rtl/riscv_test_monitor.sv - snoops register-file write-back for the end-of-test convention,
// adds a watchdog, a cycle counter and LED status.
module riscv_test_monitor
   import riscv_test_monitor_pkg::*;
#(
   parameter int CPU_WIDTH   = TMON_CPU_WIDTH,
   parameter int END_REG     = TMON_END_REG,
   parameter int RES_REG     = TMON_RES_REG,
   parameter int NUM_REG     = TMON_NUM_REG,
   parameter int TIMEOUT_CYC = 50000,
   parameter int CNT_W       = 32,
   parameter int AUTO_START  = 1,
   parameter int BLINK_BIT   = 23
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 wb_en,
   input  logic [4:0]           wb_addr,
   input  logic [CPU_WIDTH-1:0] wb_data,
   output logic                 done,
   output logic                 pass,
   output logic                 fail,
   output logic                 timeout,
   output logic [CPU_WIDTH-1:0] fail_testnum,
   output logic [CNT_W-1:0]     cycle_cnt,
   output logic [1:0]           led
);

   localparam logic [4:0]       END_A   = 5'(END_REG);
   localparam logic [4:0]       RES_A   = 5'(RES_REG);
   localparam logic [4:0]       NUM_A   = 5'(NUM_REG);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam tmon_state_e      RST_ST  = (AUTO_START != 0) ? TMON_RUN : TMON_IDLE;

   tmon_state_e            state_q, state_d;
   logic [CPU_WIDTH-1:0]   res_sh_q, res_sh_d;
   logic [CPU_WIDTH-1:0]   num_sh_q, num_sh_d;
   logic [BLINK_BIT:0]     free_q;
   logic                   in_run;
   logic                   wr_end, wr_res, wr_num, expire;

   assign in_run = (state_q == TMON_RUN) || (state_q == TMON_CHECK);

   // x0 is hard-wired zero in the core, so a write to it never means anything here.
   assign wr_end = wb_en && (wb_addr == END_A) && (END_A != 5'd0) && (wb_data == CPU_WIDTH'(1));
   assign wr_res = wb_en && (wb_addr == RES_A) && (RES_A != 5'd0);
   assign wr_num = wb_en && (wb_addr == NUM_A) && (NUM_A != 5'd0);
   assign expire = (TIMEOUT_CYC != 0) && (cycle_cnt == TO_LAST);

   always_comb begin
      state_d  = state_q;
      res_sh_d = res_sh_q;
      num_sh_d = num_sh_q;
      if (in_run) begin
         if (wr_res) res_sh_d = wb_data;
         if (wr_num) num_sh_d = wb_data;
      end
      // CHECK decides on res_sh_d so a result write landing in the CHECK cycle still counts.
      case (state_q)
         TMON_RUN: begin
            if (wr_end)      state_d = TMON_CHECK;
            else if (expire) state_d = TMON_TIMEOUT;
         end
         TMON_CHECK: state_d = (res_sh_d == CPU_WIDTH'(1)) ? TMON_PASS : TMON_FAIL;
         default:    state_d = state_q;
      endcase
      if (start) begin
         state_d  = TMON_RUN;
         res_sh_d = '0;
         num_sh_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RST_ST;
         res_sh_q <= '0;
         num_sh_q <= '0;
         free_q   <= '0;
      end else begin
         state_q  <= state_d;
         res_sh_q <= res_sh_d;
         num_sh_q <= num_sh_d;
         free_q   <= free_q + 1'b1;
      end
   end

   tmon_sat_cnt #(
      .W (CNT_W)
   ) u_cycle_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (in_run),
      .clr   (start),
      .q     (cycle_cnt)
   );

   assign pass         = (state_q == TMON_PASS);
   assign fail         = (state_q == TMON_FAIL);
   assign timeout      = (state_q == TMON_TIMEOUT);
   assign done         = pass || fail || timeout;
   assign fail_testnum = num_sh_q;
   assign led          = tmon_led(state_q, free_q[BLINK_BIT]);

endmodule

// File: doc/riscv_test_monitor.md
# riscv_test_monitor

Synthesizable end-of-test monitor for the RISC-V core. It snoops the register-file write-back port and detects the test-completion convention: end flag register written with 1, result register 1 = pass, and test-number register identifies the failing case. It adds a watchdog timeout, a cycle counter and LED status, so the same ISA tests that run under simulation also self-check on FPGA. It sits in `soc_top` beside `riscv`, fed by the write-back signals, and drives `led[1:0]`.

## Interface
- CPU_WIDTH, 32, data width of write-back bus
- END_REG, 26, end-flag register index (x26)
- RES_REG, 27, result register index (x27)
- NUM_REG, 3, test-number register index (x3, gp)
- TIMEOUT_CYC, 50000, watchdog limit in cycles; 0 disables watchdog
- CNT_W, 32, cycle counter width
- AUTO_START, 1, 1 = enter RUN directly out of reset
- BLINK_BIT, 23, free-running counter bit used for timeout blink
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; (re)arms monitor from any state
- wb_en  in  1  register-file write enable
- wb_addr  in  5  register-file write index
- wb_data  in  CPU_WIDTH  register-file write data
- done  out  1  sticky; test finished (pass, fail or timeout)
- pass  out  1  sticky pass
- fail  out  1  sticky fail (result mismatch)
- timeout  out  1  sticky watchdog expiry
- fail_testnum  out  CPU_WIDTH  shadow of NUM_REG, frozen at done
- cycle_cnt  out  CNT_W  cycles spent in RUN/CHECK, frozen at done
- led  out  2  status LEDs

## Operation
- States: IDLE, RUN, CHECK, PASS, FAIL, TIMEOUT.
- Reset: state = RUN if AUTO_START else IDLE. All outputs 0, shadows 0, counters 0.
- `start` in any state: clear shadows, cycle_cnt and sticky flags, then go to RUN next cycle. `start` overrides every other transition.
- Shadows in RUN/CHECK: a write with wb_en=1 and wb_addr==RES_REG/NUM_REG loads res_sh/num_sh. Writes to x0 are ignored, even when a parameter is set to 0.
- RUN → CHECK: wb_en && wb_addr==END_REG && wb_data==1. Writes of any other value to END_REG are ignored.
- CHECK (one cycle) uses res_sh, including a RES_REG write that lands in the CHECK cycle itself. res==1 → PASS, else → FAIL.
- RUN → TIMEOUT: TIMEOUT_CYC≠0 and cycle_cnt==TIMEOUT_CYC-1. If the end-flag write and expiry happen in the same cycle, CHECK wins.
- cycle_cnt increments in RUN and CHECK and saturates at all-ones.
- PASS/FAIL/TIMEOUT are terminal until `start` or reset. Write-back activity there is ignored, and fail_testnum/cycle_cnt hold.
- led: IDLE 00; RUN/CHECK 00; PASS 01; FAIL 10; TIMEOUT {blink,blink}, where blink = free_cnt[BLINK_BIT]. free_cnt is free-running and reset to 0.

## Timing
- Flags are registered. done/pass/fail assert 2 cycles after the end-flag write edge (edge → CHECK, CHECK → PASS/FAIL).
- timeout asserts the cycle after the expiry condition.
- fail_testnum is valid in the same cycle done rises.
- Reset mid-test: immediate asynchronous return to reset values.
- `start` in the same cycle as the end-flag write: `start` wins, and the write is discarded.

## Structure
- State encodings (`TMON_IDLE` … `TMON_TIMEOUT`, 3 bits) and the default END/RES/NUM indices go in `defines.v`, alongside `CPU_WIDTH`.
- The saturating cycle counter is a natural sub-module, `tmon_sat_cnt` (parameter W; inputs en and clr; output q). The rest is a single FSM plus shadow registers.

## Test plan
- AUTO_START=1: write x27=1, then x26=1 at cycle 10 → pass=1 and done=1 at cycle 12, led=01, cycle_cnt frozen.
- Write x3=5, x27=0, x26=1 → fail=1, fail_testnum=5, led=10.
- Write x26=1, then x27=1 on the next cycle (inside CHECK) → pass=1.
- TIMEOUT_CYC=100, no end write → timeout=1 after 100 cycles, led blinks with free_cnt[BLINK_BIT]. End write and expiry in the same cycle → CHECK path, timeout=0.
- After PASS, pulse start, then write x27=0, x26=1 → flags cleared the cycle after start, then fail=1. Writes to x0 and x26=2 never trigger completion.
- Assert rst_n low mid-RUN → all outputs 0 immediately, then state RUN/IDLE per AUTO_START.
